// File: rtl/switch_detection.sv
// Debounces two active-low push-buttons (Key[0]=ON, Key[1]=OFF) into a latched fake_switch level.
// Build option: define SWITCH_TOGGLE_EN for single-button toggle mode on Key[0].
module switch_detection #(
   parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
   parameter int unsigned CNT_W           = 20
) (
   input  logic       Sys_CLK,
   input  logic       Sys_RST,
   input  logic [1:0] Key,
   output logic       fake_switch
);

   //  state   | meaning
   //  SW_OFF  | switch level 0, waiting for an ON (or toggle) event
   //  SW_ON   | switch level 1, waiting for an OFF (or toggle) event
   typedef enum logic {
      SW_OFF = 1'b0,
      SW_ON  = 1'b1
   } sw_state_e;

   localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

   logic [1:0]       s1_q;
   logic [1:0]       s2_q;
   logic [1:0]       db_q;
   logic [1:0]       db_d;
   logic [1:0]       db_prev_q;
   logic [1:0]       press;
   logic [CNT_W-1:0] cnt_q [2];
   logic [CNT_W-1:0] cnt_d [2];
   logic             on_evt;
   logic             off_evt;
   sw_state_e        state_q;
   logic             fake_switch_q;

   // Counter restarts on any return to the accepted level, so a bounce never accumulates.
   always_comb begin
      db_d     = db_q;
      cnt_d[0] = cnt_q[0];
      cnt_d[1] = cnt_q[1];
      for (int i = 0; i < 2; i++) begin
         if (s2_q[i] == db_q[i]) begin
            cnt_d[i] = '0;
         end else if (cnt_q[i] == CNT_MAX) begin
            db_d[i]  = s2_q[i];
            cnt_d[i] = '0;
         end else begin
            cnt_d[i] = cnt_q[i] + CNT_W'(1);
         end
      end
   end

   always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
      if (!Sys_RST) begin
         s1_q      <= 2'b11;
         s2_q      <= 2'b11;
         db_q      <= 2'b11;
         db_prev_q <= 2'b11;
         cnt_q[0]  <= '0;
         cnt_q[1]  <= '0;
      end else begin
         s1_q      <= Key;
         s2_q      <= s1_q;
         db_q      <= db_d;
         db_prev_q <= db_q;
         cnt_q[0]  <= cnt_d[0];
         cnt_q[1]  <= cnt_d[1];
      end
   end

   // Falling edge of the debounced level only; releases are silent.
   assign press = db_prev_q & ~db_q;

`ifdef SWITCH_TOGGLE_EN
   assign on_evt  = press[0];
   assign off_evt = press[0];
`else
   assign on_evt  = press[0] & ~press[1];
   assign off_evt = press[1] & ~press[0];
`endif

   always_ff @(posedge Sys_CLK or negedge Sys_RST) begin
      if (!Sys_RST) begin
         state_q       <= SW_OFF;
         fake_switch_q <= 1'b0;
      end else begin
         case (state_q)
            SW_OFF: begin
               if (on_evt) begin
                  state_q       <= SW_ON;
                  fake_switch_q <= 1'b1;
               end
            end
            SW_ON: begin
               if (off_evt) begin
                  state_q       <= SW_OFF;
                  fake_switch_q <= 1'b0;
               end
            end
            default: begin
               state_q       <= SW_OFF;
               fake_switch_q <= 1'b0;
            end
         endcase
      end
   end

   assign fake_switch = fake_switch_q;

endmodule

// File: tb/tb_switch_detection.sv
// Scoreboard bench for switch_detection with a short debounce window.
module tb_switch_detection;

   localparam int DC = 16;

   logic       Sys_CLK = 1'b0;
   logic       Sys_RST;
   logic [1:0] Key;
   logic       fake_switch;

   int n_checks = 0;
   int n_errors = 0;
   int cyc      = 0;

   typedef struct {
      string tag;
      logic  val;
   } exp_t;
   exp_t sb_q[$];

   switch_detection #(.DEBOUNCE_CYCLES(DC), .CNT_W(5)) dut (
      .Sys_CLK     (Sys_CLK),
      .Sys_RST     (Sys_RST),
      .Key         (Key),
      .fake_switch (fake_switch)
   );

   always #5 Sys_CLK = ~Sys_CLK;
   always @(posedge Sys_CLK) cyc++;

   task automatic check_val(input string tag, input int obs, input int exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: observed %0d expected %0d (cycle %0d)", tag, obs, exp, cyc);
      end
   endtask

   task automatic push_exp(input string tag, input logic v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_check();
      exp_t e;
      e = sb_q.pop_front();
      check_val(e.tag, int'(fake_switch), int'(e.val));
   endtask

   task automatic step(input int n);
      repeat (n) @(posedge Sys_CLK);
      #1;
   endtask

   task automatic settle_check();
      @(negedge Sys_CLK);
      pop_check();
   endtask

   // Waits for the output to move, then checks latency window and the scoreboard level.
   task automatic wait_change(input string tag, input int t0);
      logic start;
      int   lat;
      start = fake_switch;
      lat   = -1;
      for (int i = 0; i < 40; i++) begin
         @(negedge Sys_CLK);
         if (fake_switch !== start) begin
            lat = cyc - t0;
            break;
         end
      end
      check_val({tag, "_latency_in_window"}, int'(lat >= DC + 3 && lat <= DC + 5), 1);
      pop_check();
   endtask

   task automatic hold_until(input int t0, input int n);
      while (cyc - t0 < n) step(1);
   endtask

   task automatic press_and_expect_change(input string tag, input logic [1:0] k, input logic v);
      int t0;
      Key = k;
      t0  = cyc;
      push_exp(tag, v);
      wait_change(tag, t0);
      step(1);
      hold_until(t0, 40);
      Key = 2'b11;
      step(40);
      push_exp({tag, "_after_release"}, v);
      settle_check();
   endtask

   task automatic press_no_change(input string tag, input logic [1:0] k, input logic v);
      Key = k;
      push_exp(tag, v);
      step(40);
      Key = 2'b11;
      step(40);
      settle_check();
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int t0;
      logic changed;

      Sys_RST = 1'b0;
      Key     = 2'b11;
      step(3);
      push_exp("reset_level", 1'b0);
      settle_check();
      step(1);
      Sys_RST = 1'b1;
      step(100);
      push_exp("idle_after_reset", 1'b0);
      settle_check();
      step(1);

`ifdef SWITCH_TOGGLE_EN
      press_and_expect_change("toggle_1", 2'b10, 1'b1);
      press_and_expect_change("toggle_2", 2'b10, 1'b0);
      press_no_change("key1_ignored", 2'b01, 1'b0);
      step(1);
      press_and_expect_change("toggle_3", 2'b10, 1'b1);
`else
      press_and_expect_change("on_press", 2'b10, 1'b1);
      press_and_expect_change("off_press", 2'b01, 1'b0);
      press_no_change("second_off", 2'b01, 1'b0);
      step(1);

      changed = 1'b0;
      for (int k = 0; k < 12; k++) begin
         Key = (k % 2 == 0) ? 2'b10 : 2'b11;
         for (int j = 0; j < 5; j++) begin
            @(negedge Sys_CLK);
            if (fake_switch !== 1'b0) changed = 1'b1;
            step(1);
         end
      end
      Key = 2'b11;
      step(40);
      check_val("bounce_no_change", int'(changed), 0);
      push_exp("bounce_level", 1'b0);
      settle_check();
      step(1);

      press_no_change("simul_from_off", 2'b00, 1'b0);
      step(1);
      press_and_expect_change("on_press_2", 2'b10, 1'b1);
      press_no_change("simul_from_on", 2'b00, 1'b1);
`endif
      step(1);

      Key = 2'b10;
      step(10);
      Sys_RST = 1'b0;
      #1;
      push_exp("reset_mid_count_immediate", 1'b0);
      pop_check();
      step(3);
      Sys_RST = 1'b1;
      t0 = cyc;
      push_exp("rise_after_reset", 1'b1);
      wait_change("rise_after_reset", t0);
      step(1);
      Key = 2'b11;
      step(30);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
